// File: rtl/resamp_gain_chain.sv
// Decimate-by-N, gain with saturation, FWFT sample FIFO and a zero-order-hold /
// linear interpolator that re-expands the stream to the input rate.
`timescale 1ns/1ps
module resamp_gain_chain #(
  parameter int DATA_WIDTH  = 14,
  parameter int DECIM_LOG2  = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int GAIN_WIDTH  = 8,
  parameter int START_LEVEL = 4
) (
  input  logic                          clk,
  input  logic                          rst_in,
  input  logic                          din_valid,
  input  logic signed [DATA_WIDTH-1:0]  din,
  input  logic [GAIN_WIDTH-1:0]         gain,
  input  logic                          mode,
  input  logic                          run_en,
  input  logic                          clr_flags,
  output logic signed [DATA_WIDTH-1:0]  dout,
  output logic                          dout_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          sat_flag,
  output logic                          ovf_flag,
  output logic                          unf_flag,
  output logic [1:0]                    fsm_state
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int ACC_W  = DATA_WIDTH + DECIM_LOG2;
  localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int DIFF_W = DATA_WIDTH + 1;
  localparam int IP_W   = DATA_WIDTH + 1 + DECIM_LOG2;
  localparam int MAX_I  = (1 << (DATA_WIDTH - 1)) - 1;
  localparam int MIN_I  = -(1 << (DATA_WIDTH - 1));

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

  // Handshake: din_valid qualifies din for one cycle; there is no back-pressure,
  // the FIFO absorbs rate mismatch and flags overflow/underflow instead.

  // ---------------- decimator ----------------
  logic signed [ACC_W-1:0]      acc;
  logic signed [ACC_W-1:0]      din_ext;
  logic [DECIM_LOG2-1:0]        dec_cnt;
  logic                         dec_valid;
  logic signed [DATA_WIDTH-1:0] dec_sample;

  assign din_ext = ACC_W'(din);

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      acc        <= '0;
      dec_cnt    <= '0;
      dec_valid  <= 1'b0;
      dec_sample <= '0;
    end else begin
      dec_valid <= 1'b0;
      if (din_valid) begin
        if (&dec_cnt) begin
          dec_sample <= DATA_WIDTH'((acc + din_ext) >>> DECIM_LOG2);
          dec_valid  <= 1'b1;
          acc        <= '0;
          dec_cnt    <= '0;
        end else begin
          acc     <= acc + din_ext;
          dec_cnt <= dec_cnt + DECIM_LOG2'(1);
        end
      end
    end
  end

  // ---------------- gain stage ----------------
  logic signed [PROD_W-1:0]     prod;
  logic signed [PROD_W-1:0]     prod_shift;
  logic                         sat_hi, sat_lo, clip;
  logic signed [DATA_WIDTH-1:0] gain_res;
  logic                         g_valid;
  logic signed [DATA_WIDTH-1:0] g_sample;

  always_comb begin
    prod       = PROD_W'(dec_sample) * PROD_W'($signed({1'b0, gain}));
    prod_shift = prod >>> (GAIN_WIDTH - 1);
    sat_hi     = prod_shift > PROD_W'(MAX_I);
    sat_lo     = prod_shift < PROD_W'(MIN_I);
    gain_res   = sat_hi ? DATA_WIDTH'(MAX_I) :
                 sat_lo ? DATA_WIDTH'(MIN_I) : DATA_WIDTH'(prod_shift);
    clip       = dec_valid & (sat_hi | sat_lo);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      g_valid  <= 1'b0;
      g_sample <= '0;
    end else begin
      g_valid <= dec_valid;
      if (dec_valid) g_sample <= gain_res;
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic signed [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]                wr_ptr, rd_ptr;
  logic                         fifo_full, fifo_empty, push_ok, ovf_set, pop;
  logic signed [DATA_WIDTH-1:0] head;

  assign fifo_full  = fifo_level == (AW+1)'(FIFO_DEPTH);
  assign fifo_empty = fifo_level == '0;
  // A pop frees the slot in the same cycle, so a full FIFO still takes the push.
  assign push_ok    = g_valid & (~fifo_full | pop);
  assign ovf_set    = g_valid & fifo_full & ~pop;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= g_sample;
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + (AW+1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW+1)'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // ---------------- interpolator FSM ----------------
  state_t                       state, state_nxt;
  logic                         prime_second;
  logic [DECIM_LOG2-1:0]        k;
  logic                         mode_q;
  logic signed [DATA_WIDTH-1:0] prev, cur;
  logic                         load_prev, load_cur, shift_pc, out_en, unf_set, latch_mode;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    load_prev  = 1'b0;
    load_cur   = 1'b0;
    shift_pc   = 1'b0;
    out_en     = 1'b0;
    unf_set    = 1'b0;
    latch_mode = 1'b0;
    case (state)
      IDLE: begin
        if (run_en && fifo_level >= (AW+1)'(START_LEVEL)) begin
          state_nxt  = PRIME;
          latch_mode = 1'b1;
        end
      end
      PRIME: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (!prime_second) begin
            load_prev = 1'b1;
          end else begin
            load_cur  = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        out_en = 1'b1;
        if (&k) begin
          if (!run_en) begin
            state_nxt = IDLE;
          end else if (!fifo_empty) begin
            pop      = 1'b1;
            shift_pc = 1'b1;
          end else begin
            unf_set   = 1'b1;
            out_en    = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Linear interpolation: the difference is one bit wider than a sample so it never wraps.
  logic signed [DIFF_W-1:0]     diff;
  logic signed [IP_W-1:0]       ip_prod;
  logic signed [DATA_WIDTH-1:0] interp, out_val;

  always_comb begin
    diff    = DIFF_W'(cur) - DIFF_W'(prev);
    ip_prod = IP_W'(diff) * IP_W'($signed({1'b0, k}));
    interp  = prev + DATA_WIDTH'(ip_prod >>> DECIM_LOG2);
    out_val = mode_q ? interp : prev;
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      prime_second <= 1'b0;
      k            <= '0;
      mode_q       <= 1'b0;
      prev         <= '0;
      cur          <= '0;
      dout         <= '0;
      dout_valid   <= 1'b0;
    end else begin
      if (load_prev)       prime_second <= 1'b1;
      else if (load_cur)   prime_second <= 1'b0;
      if (state == RUN)    k <= k + DECIM_LOG2'(1);
      else                 k <= '0;
      if (latch_mode)      mode_q <= mode;
      if (load_prev)       prev <= head;
      if (load_cur)        cur  <= head;
      if (shift_pc) begin
        prev <= cur;
        cur  <= head;
      end
      dout_valid <= out_en;
      if (out_en) dout <= out_val;
    end
  end

  // ---------------- sticky flags: a set in the clearing cycle wins ----------------
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
      unf_flag <= 1'b0;
    end else begin
      sat_flag <= clip    | (sat_flag & ~clr_flags);
      ovf_flag <= ovf_set | (ovf_flag & ~clr_flags);
      unf_flag <= unf_set | (unf_flag & ~clr_flags);
    end
  end

endmodule
